// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: RV32I memory stage issuing aligned load/store requests and producing one writeback beat per instruction
module mem_stage_lsu #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [31:0]       ex_alu_out,
  input  logic [31:0]       ex_store_data,
  input  logic              ex_is_load,
  input  logic              ex_is_store,
  input  logic [2:0]        ex_funct3,
  input  logic [4:0]        ex_rd,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [31:0]       dmem_rdata,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_data,
  output logic              wb_misalign
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP} state_t;
  state_t state, state_d;
  logic [2:0]  f3_q;
  logic [4:0]  rd_q;
  logic [1:0]  off_q;
  logic        is_mem, illegal, misalign, bad;
  logic [1:0]  a;
  logic [3:0]  be;
  logic [31:0] wdata, sh, load_data;
  assign a        = ex_alu_out[1:0];
  assign is_mem   = ex_is_load | ex_is_store;
  assign illegal  = ex_is_store ? (ex_funct3[2] | (ex_funct3[1:0] == 2'b11))
                                : (ex_funct3 == 3'b011 || ex_funct3[2:1] == 2'b11);
  assign misalign = (ex_funct3[1:0] == 2'b01 && a[0]) || (ex_funct3[1:0] == 2'b10 && a != 2'b00);
  assign bad      = illegal | misalign;
  assign be       = ex_funct3[1:0] == 2'b00 ? 4'b0001 << a :
                    ex_funct3[1:0] == 2'b01 ? 4'b0011 << {a[1], 1'b0} : 4'b1111;
  assign wdata    = ex_funct3[1:0] == 2'b00 ? {4{ex_store_data[7:0]}} :
                    ex_funct3[1:0] == 2'b01 ? {2{ex_store_data[15:0]}} : ex_store_data;
  // halves are aligned, so shifting by the byte offset lands the lane at bit 0
  assign sh        = dmem_rdata >> {off_q, 3'b000};
  assign load_data = f3_q == 3'b000 ? {{24{sh[7]}}, sh[7:0]} :
                     f3_q == 3'b001 ? {{16{sh[15]}}, sh[15:0]} :
                     f3_q == 3'b100 ? {24'h0, sh[7:0]} :
                     f3_q == 3'b101 ? {16'h0, sh[15:0]} : dmem_rdata;
  assign ex_ready  = state == IDLE;
  always_comb begin
    state_d = state;
    case (state)
      IDLE:     state_d = (ex_valid && is_mem && !bad) ? REQ : IDLE;
      REQ:      state_d = dmem_gnt ? (dmem_we ? IDLE : WAIT_RSP) : REQ;
      WAIT_RSP: state_d = dmem_rvalid ? IDLE : WAIT_RSP;
      default:  state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      dmem_addr   <= '0;
      dmem_be     <= 4'h0;
      dmem_wdata  <= 32'h0;
      wb_valid    <= 1'b0;
      wb_we       <= 1'b0;
      wb_rd       <= 5'h0;
      wb_data     <= 32'h0;
      wb_misalign <= 1'b0;
      f3_q        <= 3'h0;
      rd_q        <= 5'h0;
      off_q       <= 2'h0;
    end else begin
      state       <= state_d;
      wb_valid    <= 1'b0;
      wb_we       <= 1'b0;
      wb_misalign <= 1'b0;
      case (state)
        IDLE: if (ex_valid) begin
          if (!is_mem) begin
            wb_valid <= 1'b1;
            wb_we    <= |ex_rd;
            wb_rd    <= ex_rd;
            wb_data  <= ex_alu_out;
          end else if (bad) begin
            wb_valid    <= 1'b1;
            wb_misalign <= 1'b1;
            wb_rd       <= ex_rd;
          end else begin
            dmem_req   <= 1'b1;
            dmem_we    <= ex_is_store;
            dmem_addr  <= {ex_alu_out[ADDR_W-1:2], 2'b00};
            dmem_be    <= be;
            dmem_wdata <= ex_is_store ? wdata : 32'h0;
            f3_q       <= ex_funct3;
            rd_q       <= ex_rd;
            off_q      <= a;
          end
        end
        REQ: if (dmem_gnt) begin
          dmem_req <= 1'b0;
          wb_valid <= dmem_we;
          wb_rd    <= rd_q;
        end
        WAIT_RSP: if (dmem_rvalid) begin
          wb_valid <= 1'b1;
          wb_we    <= |rd_q;
          wb_rd    <= rd_q;
          wb_data  <= load_data;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: directed-vector self-checking bench for mem_stage_lsu
module tb_mem_stage_lsu;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_ready, ex_is_load, ex_is_store;
  logic [31:0] ex_alu_out, ex_store_data;
  logic [2:0]  ex_funct3;
  logic [4:0]  ex_rd;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        wb_valid, wb_we, wb_misalign;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  int checks = 0;
  int failures = 0;
  mem_stage_lsu #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_alu_out(ex_alu_out), .ex_store_data(ex_store_data), .ex_is_load(ex_is_load),
    .ex_is_store(ex_is_store), .ex_funct3(ex_funct3), .ex_rd(ex_rd),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd),
    .wb_data(wb_data), .wb_misalign(wb_misalign)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [31:0] alu, input logic [31:0] sd, input logic ld,
                       input logic st, input logic [2:0] f3, input logic [4:0] rd);
    ex_valid = 1'b1; ex_alu_out = alu; ex_store_data = sd;
    ex_is_load = ld; ex_is_store = st; ex_funct3 = f3; ex_rd = rd;
    tick;
    ex_valid = 1'b0; ex_is_load = 1'b0; ex_is_store = 1'b0;
  endtask
  task automatic do_load(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                         input logic [4:0] rd, input logic [31:0] rdata,
                         input logic [3:0] exp_be, input logic [31:0] exp);
    issue(addr, 32'h0, 1'b1, 1'b0, f3, rd);
    chk({tag, "_req"}, dmem_req, 1);
    chk({tag, "_we"}, dmem_we, 0);
    chk({tag, "_addr"}, dmem_addr, {addr[31:2], 2'b00});
    chk({tag, "_be"}, dmem_be, exp_be);
    dmem_gnt = 1'b1;
    tick;
    dmem_gnt = 1'b0;
    chk({tag, "_req_drop"}, dmem_req, 0);
    dmem_rvalid = 1'b1; dmem_rdata = rdata;
    tick;
    dmem_rvalid = 1'b0;
    chk({tag, "_wbv"}, wb_valid, 1);
    chk({tag, "_wbwe"}, wb_we, rd != 0);
    chk({tag, "_data"}, wb_data, exp);
    chk({tag, "_rdy"}, ex_ready, 1);
  endtask
  task automatic bad_op(input string tag, input logic [31:0] addr, input logic ld,
                        input logic st, input logic [2:0] f3);
    issue(addr, 32'h5555_5555, ld, st, f3, 5'd9);
    chk({tag, "_noreq"}, dmem_req, 0);
    chk({tag, "_wbv"}, wb_valid, 1);
    chk({tag, "_mis"}, wb_misalign, 1);
    chk({tag, "_wbwe"}, wb_we, 0);
    tick;
    chk({tag, "_pulse"}, wb_valid, 0);
    chk({tag, "_noreq2"}, dmem_req, 0);
  endtask
  initial begin
    rst_n = 1'b0; ex_valid = 1'b0; ex_alu_out = 32'h0; ex_store_data = 32'h0;
    ex_is_load = 1'b0; ex_is_store = 1'b0; ex_funct3 = 3'h0; ex_rd = 5'h0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    tick; tick;
    chk("rst_req", dmem_req, 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_be", dmem_be, 0);
    chk("rst_wbv", wb_valid, 0);
    chk("rst_wbdata", wb_data, 0);
    chk("rst_rdy", ex_ready, 1);
    rst_n = 1'b1;
    tick;
    issue(32'h1234_5678, 32'h0, 1'b0, 1'b0, 3'b000, 5'd5);
    chk("alu_wbv", wb_valid, 1);
    chk("alu_wbwe", wb_we, 1);
    chk("alu_rd", wb_rd, 5);
    chk("alu_data", wb_data, 32'h1234_5678);
    chk("alu_noreq", dmem_req, 0);
    tick;
    chk("alu_pulse", wb_valid, 0);
    issue(32'hCAFE_0001, 32'h0, 1'b0, 1'b0, 3'b000, 5'd0);
    chk("alu0_wbv", wb_valid, 1);
    chk("alu0_wbwe", wb_we, 0);
    chk("alu0_data", wb_data, 32'hCAFE_0001);
    tick;
    issue(32'h0000_0103, 32'hAABB_CCDD, 1'b0, 1'b1, 3'b000, 5'd0);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) dmem_gnt = 1'b1;
      chk("sb_req", dmem_req, 1);
      chk("sb_we", dmem_we, 1);
      chk("sb_addr", dmem_addr, 32'h100);
      chk("sb_be", dmem_be, 4'b1000);
      chk("sb_wdata", dmem_wdata, 32'hDDDD_DDDD);
      chk("sb_rdy", ex_ready, 0);
      chk("sb_nowb", wb_valid, 0);
      tick;
    end
    dmem_gnt = 1'b0;
    chk("sb_reqoff", dmem_req, 0);
    chk("sb_wbv", wb_valid, 1);
    chk("sb_wbwe", wb_we, 0);
    chk("sb_rdy_end", ex_ready, 1);
    tick;
    issue(32'h0000_0402, 32'h1122_3344, 1'b0, 1'b1, 3'b001, 5'd0);
    chk("sh_be", dmem_be, 4'b1100);
    chk("sh_wdata", dmem_wdata, 32'h3344_3344);
    dmem_gnt = 1'b1; tick; dmem_gnt = 1'b0;
    chk("sh_wbv", wb_valid, 1);
    tick;
    do_load("lb", 32'h202, 3'b000, 5'd3, 32'h80FF_8001, 4'b0100, 32'hFFFF_FFFF);
    do_load("lbu", 32'h202, 3'b100, 5'd3, 32'h80FF_8001, 4'b0100, 32'h0000_00FF);
    do_load("lh", 32'h202, 3'b001, 5'd3, 32'h80FF_8001, 4'b1100, 32'hFFFF_80FF);
    do_load("lhu", 32'h202, 3'b101, 5'd3, 32'h80FF_8001, 4'b1100, 32'h0000_80FF);
    do_load("lb1", 32'h201, 3'b000, 5'd4, 32'h1234_7F56, 4'b0010, 32'h0000_007F);
    do_load("lw0", 32'h204, 3'b010, 5'd0, 32'h8765_4321, 4'b1111, 32'h8765_4321);
    bad_op("lw_mis", 32'h6, 1'b1, 1'b0, 3'b010);
    bad_op("lh_mis", 32'h1, 1'b1, 1'b0, 3'b001);
    bad_op("st_ill", 32'h0, 1'b0, 1'b1, 3'b011);
    bad_op("ld_ill", 32'h0, 1'b1, 1'b0, 3'b110);
    issue(32'h300, 32'h0, 1'b1, 1'b0, 3'b010, 5'd7);
    dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    chk("sp_rdy1", ex_ready, 0);
    tick;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("sp_rdy", ex_ready, 0);
      chk("sp_nowb", wb_valid, 0);
      chk("sp_noreq", dmem_req, 0);
      tick;
    end
    dmem_rvalid = 1'b1; dmem_rdata = 32'h1122_3344;
    chk("sp_rdy5", ex_ready, 0);
    chk("sp_nowb5", wb_valid, 0);
    tick;
    dmem_rvalid = 1'b0;
    chk("sp_wbv", wb_valid, 1);
    chk("sp_data", wb_data, 32'h1122_3344);
    chk("sp_rd", wb_rd, 7);
    tick;
    issue(32'h404, 32'h0, 1'b1, 1'b0, 3'b010, 5'd8);
    dmem_gnt = 1'b1; tick; dmem_gnt = 1'b0;
    chk("rm_wait", ex_ready, 0);
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    chk("rm_req", dmem_req, 0);
    chk("rm_wbv", wb_valid, 0);
    chk("rm_rdy", ex_ready, 1);
    dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFF_0000;
    tick;
    dmem_rvalid = 1'b0;
    chk("rm_late_wbv", wb_valid, 0);
    chk("rm_late_rdy", ex_ready, 1);
    tick;
    chk("rm_late_wbv2", wb_valid, 0);
    chk("rm_late_req", dmem_req, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
